// File: rtl/pipe_pkg.sv
// Shared types for the core's inter-stage registers: occupancy states, per-stage
// payload layouts and the masks of their side-effecting control bits.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_res;
    logic [31:0] rs2_data;
    logic [31:0] csr_wdata;
    logic [4:0]  rd;
    logic [2:0]  mem_whb;
    logic [1:0]  csr_sel;
    logic        reg_write;
    logic        mem_re;
    logic        mem_wr;
  } exe_mem_t;

  localparam int unsigned EXE_MEM_W = $bits(exe_mem_t);

  function automatic exe_mem_t exe_mem_ctrl_mask();
    exe_mem_t m;
    m           = '0;
    m.mem_whb   = '1;
    m.csr_sel   = '1;
    m.reg_write = 1'b1;
    m.mem_re    = 1'b1;
    m.mem_wr    = 1'b1;
    return m;
  endfunction

  localparam exe_mem_t EXE_MEM_CTRL_MASK = exe_mem_ctrl_mask();

endpackage

// File: rtl/pipe_stall_ctr.sv
// Saturating up-counter of stall cycles; only reset clears it.
module pipe_stall_ctr #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush, bubble control
// zeroing and an optional skid entry so in_ready can come straight from a flop.
//
// state | meaning
// EMPTY | main invalid, skid invalid
// ONE   | main valid, skid invalid
// TWO   | main valid, skid valid (input blocked)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned          PAYLOAD_W = 141,
  parameter logic [PAYLOAD_W-1:0] CTRL_MASK = '0,
  parameter bit                   SKID_EN   = 1'b1,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [CNT_W-1:0]     stall_cnt
);

  stage_state_e         r_state;
  logic [PAYLOAD_W-1:0] r_main;
  logic [PAYLOAD_W-1:0] r_skid;
  logic                 r_in_ready;
  logic                 w_in_xfer;
  logic                 w_out_xfer;
  logic                 w_stall;

  assign out_valid  = (r_state != EMPTY);
  assign out_data   = r_main;
  assign in_ready   = SKID_EN ? r_in_ready : (!out_valid || out_ready);
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;
  assign w_stall    = out_valid && !out_ready;

  // Main loses its controls whenever it goes invalid, so a bubble never
  // carries a stale write enable downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= EMPTY;
      r_main     <= '0;
      r_skid     <= '0;
      r_in_ready <= 1'b1;
    end else if (flush) begin
      r_state    <= EMPTY;
      r_main     <= r_main & ~CTRL_MASK;
      r_in_ready <= 1'b1;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            r_main  <= in_data;
            r_state <= ONE;
          end
        end
        ONE: begin
          if (w_in_xfer && !w_out_xfer && SKID_EN) begin
            r_skid     <= in_data;
            r_state    <= TWO;
            r_in_ready <= 1'b0;
          end else if (w_in_xfer) begin
            r_main <= in_data;
          end else if (w_out_xfer) begin
            r_main  <= r_main & ~CTRL_MASK;
            r_state <= EMPTY;
          end
        end
        TWO: begin
          if (w_out_xfer) begin
            r_main     <= r_skid;
            r_state    <= ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= EMPTY;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  pipe_stall_ctr #(
    .CNT_W (CNT_W)
  ) u_stall_ctr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_stall),
    .o_cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid and single-entry variants plus a
// 4-bit counter variant, with a small queue model for the random phase.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int W = 141;
  localparam logic [W-1:0] MASK = {133'd0, 8'hFF};
  localparam logic [W-1:0] DA5 = {133'd0, 8'hA5};
  localparam logic [W-1:0] D0 = {13'h0A1, 32'hD0D0_0001, 32'h1111_2222, 32'h3333_4444, 32'h5555_66A7};
  localparam logic [W-1:0] D1 = {13'h1B2, 32'hD1D1_0002, 32'h2222_3333, 32'h4444_5555, 32'h6666_77B3};
  localparam logic [W-1:0] D2 = {13'h0C3, 32'hD2D2_0003, 32'h3333_4444, 32'h5555_6666, 32'h7777_88C5};
  localparam logic [W-1:0] E0 = {13'h111, 32'hE0E0_E0E0, 32'h0, 32'h0, 32'h0000_12FF};
  localparam logic [W-1:0] E1 = {13'h122, 32'hE1E1_E1E1, 32'h0, 32'h0, 32'h0000_34FF};
  localparam logic [W-1:0] E2 = {13'h133, 32'hE2E2_E2E2, 32'h0, 32'h0, 32'h0000_56FF};
  localparam logic [W-1:0] F0 = {13'h044, 32'hF0F0_F0F0, 32'h1, 32'h2, 32'h0000_0081};
  localparam logic [W-1:0] G0 = {13'h1FF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  localparam logic [W-1:0] H0 = {13'h055, 32'h4848_4848, 32'h0, 32'h0, 32'h0000_0048};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic in_valid, flush, out_ready;
  logic [W-1:0] in_data;
  logic a_in_ready, a_out_valid;
  logic [W-1:0] a_out_data;
  logic [15:0] a_cnt;
  logic s_in_ready, s_out_valid;
  logic [W-1:0] s_out_data;
  logic [3:0] s_cnt;
  logic n_in_valid, n_flush, n_out_ready;
  logic [W-1:0] n_in_data;
  logic n_in_ready, n_out_valid;
  logic [W-1:0] n_out_data;
  logic [15:0] n_cnt;

  int n_vec = 0;
  int n_err = 0;

  pipe_stage_reg #(.PAYLOAD_W(W), .CTRL_MASK(EXE_MEM_CTRL_MASK), .SKID_EN(1'b1), .CNT_W(16)) u_skid (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .stall_cnt(a_cnt));

  pipe_stage_reg #(.PAYLOAD_W(W), .CTRL_MASK(EXE_MEM_CTRL_MASK), .SKID_EN(1'b1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .stall_cnt(s_cnt));

  pipe_stage_reg #(.PAYLOAD_W(W), .CTRL_MASK(EXE_MEM_CTRL_MASK), .SKID_EN(1'b0), .CNT_W(16)) u_ns (
    .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
    .flush(n_flush), .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
    .stall_cnt(n_cnt));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid = 0; flush = 0; out_ready = 0; in_data = '0;
    n_in_valid = 0; n_flush = 0; n_out_ready = 0; n_in_data = '0;
    #1 rst = 1'b0;
    #2;
    n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b expected 0", a_out_valid); end
    n_vec++; if (a_out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %h expected 0", a_out_data); end
    n_vec++; if (a_cnt !== 16'd0) begin n_err++; $display("FAIL reset_stall_cnt: got %0d expected 0", a_cnt); end
    n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_skid: got %0b expected 1", a_in_ready); end
    n_vec++; if (n_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_noskid: got %0b expected 1", n_in_ready); end
    n_vec++; if (n_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid_noskid: got %0b expected 0", n_out_valid); end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_latency();
    in_valid = 1; in_data = DA5; out_ready = 1;
    step();
    n_vec++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL latency_valid: got %0b expected 1", a_out_valid); end
    n_vec++; if (a_out_data !== DA5) begin n_err++; $display("FAIL latency_data: got %h expected %h", a_out_data, DA5); end
    n_vec++; if (a_cnt !== 16'd0) begin n_err++; $display("FAIL latency_stall_cnt: got %0d expected 0", a_cnt); end
    in_valid = 0;
    step();
    n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid: got %0b expected 0", a_out_valid); end
    n_vec++; if ((a_out_data & MASK) !== '0) begin n_err++; $display("FAIL drain_ctrl_zero: got %h expected 0", a_out_data & MASK); end
  endtask

  task automatic test_skid_stall();
    out_ready = 0; in_valid = 1; in_data = D0;
    n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL skid_ready_empty: got %0b expected 1", a_in_ready); end
    step();
    in_data = D1;
    n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL skid_ready_one: got %0b expected 1", a_in_ready); end
    n_vec++; if (a_out_data !== D0) begin n_err++; $display("FAIL skid_main_d0: got %h expected %h", a_out_data, D0); end
    step();
    in_data = D2;
    n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL skid_ready_two: got %0b expected 0", a_in_ready); end
    step();
    n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL skid_ready_hold: got %0b expected 0", a_in_ready); end
    step();
    n_vec++; if (a_cnt !== 16'd3) begin n_err++; $display("FAIL skid_stall_cnt: got %0d expected 3", a_cnt); end
    n_vec++; if (a_out_data !== D0) begin n_err++; $display("FAIL skid_out_d0: got %h expected %h", a_out_data, D0); end
    out_ready = 1;
    step();
    n_vec++; if (a_out_data !== D1) begin n_err++; $display("FAIL skid_out_d1: got %h expected %h", a_out_data, D1); end
    n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL skid_ready_reopen: got %0b expected 1", a_in_ready); end
    step();
    in_valid = 0;
    n_vec++; if (a_out_data !== D2) begin n_err++; $display("FAIL skid_out_d2: got %h expected %h", a_out_data, D2); end
    n_vec++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL skid_valid_d2: got %0b expected 1", a_out_valid); end
    step();
    n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL skid_drained: got %0b expected 0", a_out_valid); end
    n_vec++; if (a_cnt !== 16'd3) begin n_err++; $display("FAIL skid_cnt_after: got %0d expected 3", a_cnt); end
  endtask

  task automatic test_flush();
    out_ready = 0; in_valid = 1; in_data = E0;
    step();
    in_data = E1;
    step();
    n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL flush_pre_two: got %0b expected 0", a_in_ready); end
    flush = 1; in_data = E2;
    step();
    flush = 0; in_valid = 0;
    n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %0b expected 0", a_out_valid); end
    n_vec++; if ((a_out_data & MASK) !== '0) begin n_err++; $display("FAIL flush_ctrl_zero: got %h expected 0", a_out_data & MASK); end
    n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %0b expected 1", a_in_ready); end
    n_vec++; if (a_cnt !== 16'd5) begin n_err++; $display("FAIL flush_stall_cnt: got %0d expected 5", a_cnt); end
    out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_ghost: got %0b expected 0", a_out_valid); end
    end
  endtask

  task automatic test_stall_sat();
    out_ready = 0; in_valid = 1; in_data = F0;
    step();
    in_valid = 0;
    for (int i = 0; i < 10; i++) step();
    n_vec++; if (s_cnt !== 4'd15) begin n_err++; $display("FAIL sat_reach: got %0d expected 15", s_cnt); end
    n_vec++; if (a_cnt !== 16'd15) begin n_err++; $display("FAIL wide_cnt_15: got %0d expected 15", a_cnt); end
    for (int i = 0; i < 10; i++) step();
    n_vec++; if (s_cnt !== 4'd15) begin n_err++; $display("FAIL sat_hold: got %0d expected 15", s_cnt); end
    n_vec++; if (a_cnt !== 16'd25) begin n_err++; $display("FAIL wide_cnt_25: got %0d expected 25", a_cnt); end
    flush = 1;
    step();
    flush = 0;
    n_vec++; if (s_cnt !== 4'd15) begin n_err++; $display("FAIL sat_after_flush: got %0d expected 15", s_cnt); end
    n_vec++; if (a_cnt !== 16'd26) begin n_err++; $display("FAIL wide_after_flush: got %0d expected 26", a_cnt); end
    n_vec++; if (s_out_valid !== 1'b0) begin n_err++; $display("FAIL sat_flush_valid: got %0b expected 0", s_out_valid); end
    step();
    n_vec++; if (s_cnt !== 4'd15) begin n_err++; $display("FAIL sat_idle_hold: got %0d expected 15", s_cnt); end
  endtask

  task automatic test_async_reset();
    out_ready = 0; in_valid = 1; in_data = G0;
    step();
    in_valid = 0;
    n_vec++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL areset_pre_valid: got %0b expected 1", a_out_valid); end
    #2 rst = 1'b0;
    #1;
    n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid: got %0b expected 0", a_out_valid); end
    n_vec++; if (a_out_data !== '0) begin n_err++; $display("FAIL areset_data: got %h expected 0", a_out_data); end
    n_vec++; if (a_cnt !== 16'd0) begin n_err++; $display("FAIL areset_cnt: got %0d expected 0", a_cnt); end
    n_vec++; if (s_cnt !== 4'd0) begin n_err++; $display("FAIL areset_sat_cnt: got %0d expected 0", s_cnt); end
    n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL areset_in_ready: got %0b expected 1", a_in_ready); end
    #2 rst = 1'b1;
    step();
  endtask

  task automatic test_ns_backpressure();
    n_flush = 0; n_out_ready = 0; n_in_valid = 1; n_in_data = H0;
    #1;
    n_vec++; if (n_in_ready !== 1'b1) begin n_err++; $display("FAIL ns_ready_empty: got %0b expected 1", n_in_ready); end
    step();
    n_in_valid = 0;
    #1;
    n_vec++; if (n_in_ready !== 1'b0) begin n_err++; $display("FAIL ns_ready_blocked: got %0b expected 0", n_in_ready); end
    n_vec++; if (n_out_data !== H0) begin n_err++; $display("FAIL ns_data: got %h expected %h", n_out_data, H0); end
    n_out_ready = 1;
    #1;
    n_vec++; if (n_in_ready !== 1'b1) begin n_err++; $display("FAIL ns_ready_follow_hi: got %0b expected 1", n_in_ready); end
    n_out_ready = 0;
    #1;
    n_vec++; if (n_in_ready !== 1'b0) begin n_err++; $display("FAIL ns_ready_follow_lo: got %0b expected 0", n_in_ready); end
    n_out_ready = 1;
    step();
    n_vec++; if (n_out_valid !== 1'b0) begin n_err++; $display("FAIL ns_drain: got %0b expected 0", n_out_valid); end
  endtask

  task automatic test_ns_random();
    logic [W-1:0] q[$];
    logic [159:0] tmp;
    logic exp_valid, exp_ready;
    int n_out = 0;
    for (int i = 0; i < 10000; i++) begin
      n_in_valid  = ($urandom_range(0, 3) != 0);
      n_out_ready = ($urandom_range(0, 2) != 0);
      n_flush     = ($urandom_range(0, 31) == 0);
      tmp = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      n_in_data = tmp[W-1:0];
      #1;
      exp_valid = (q.size() != 0);
      exp_ready = !exp_valid || n_out_ready;
      n_vec++; if (n_out_valid !== exp_valid) begin n_err++; $display("FAIL rnd_valid cyc %0d: got %0b expected %0b", i, n_out_valid, exp_valid); end
      n_vec++; if (n_in_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready cyc %0d: got %0b expected %0b", i, n_in_ready, exp_ready); end
      if (exp_valid) begin
        n_vec++; if (n_out_data !== q[0]) begin n_err++; $display("FAIL rnd_data cyc %0d: got %h expected %h", i, n_out_data, q[0]); end
        if (n_out_ready) begin
          void'(q.pop_front());
          n_out++;
        end
      end
      if (n_flush) q.delete();
      else if (n_in_valid && exp_ready) q.push_back(n_in_data);
      step();
    end
    n_in_valid = 0; n_flush = 0;
    n_vec++; if (n_out < 1000) begin n_err++; $display("FAIL rnd_throughput: got %0d transfers expected at least 1000", n_out); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_skid_stall();
    test_flush();
    test_stall_sat();
    test_async_reset();
    test_ns_backpressure();
    test_ns_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with valid/ready handshake, synchronous flush, bubble control-zeroing, optional skid entry and a saturating stall counter. It replaces the fixed-field, always-advancing inter-stage registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB) of the RISC-V core. Each stage instantiates it with its own packed payload, so stalls and flushes are handled uniformly without per-stage hand-written registers.

## Interface
- PAYLOAD_W, 141: width of the packed stage payload. 141 = EXE/MEM fields: 4×32 + 5 + 3 + 2 + 3×1.
- CTRL_MASK, {PAYLOAD_W{1'b0}}: bit mask of payload bits that are side-effecting controls (RegWrite, MemReWr, …). These bits are forced to 0 in any bubble.
- SKID_EN, 1: 1 = two-entry stage (main + skid) with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage can accept this cycle
- in_data  in  PAYLOAD_W  upstream payload
- flush  in  1  synchronous kill of all held and incoming entries
- out_valid  out  1  main entry valid
- out_ready  in  1  downstream accepts this cycle
- out_data  out  PAYLOAD_W  main entry payload
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- States (SKID_EN=1):
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - TWO: main valid, skid valid.
- Transitions with flush=0:
  - EMPTY + input → ONE; main ← in_data.
  - ONE + input, no output → TWO; skid ← in_data.
  - ONE + input + output → ONE; main ← in_data.
  - ONE + output only → EMPTY.
  - TWO + output → ONE; main ← skid.
  - TWO never accepts input, since in_ready=0.
- SKID_EN=0:
  - States are EMPTY and ONE only.
  - in_ready = !out_valid || out_ready.
- Flush:
  - flush=1 has priority over every other event. Next state is EMPTY.
  - Any input transfer in the flush cycle is discarded.
  - An output transfer in the flush cycle still completes, since downstream sampled it.
- Bubble zeroing:
  - In every cycle where out_valid=0, out_data & CTRL_MASK = 0.
  - Implementation: main-register masked bits are cleared whenever main becomes invalid (flush, or drain to EMPTY).
- Unmasked bits of out_data are don't-care while out_valid=0, except after reset, when they are 0.
- stall_cnt:
  - Increments by 1 in each cycle with out_valid && !out_ready.
  - Holds at 2^CNT_W−1.
  - Cleared only by reset. Unaffected by flush.

## Timing
- Reset (rst=0, asynchronous):
  - out_valid=0, out_data=0, stall_cnt=0.
  - in_ready=1 in both modes; state EMPTY.
  - Reset in any state discards all entries immediately.
- Latency: an input accepted in cycle N appears with out_valid=1 in cycle N+1 when the stage was EMPTY or draining.
- Throughput: one transfer per cycle while out_ready=1.
- SKID_EN=1:
  - in_ready is a flop output, = (next state ≠ TWO).
  - No combinational path from out_ready to in_ready.
- SKID_EN=0: combinational path out_ready → in_ready.
- in_data must be stable only in the accept cycle.
- out_data and out_valid change only on rising clk, or on reset assertion.
- Order is strictly FIFO: the skid entry never bypasses main.

## Structure
- Shared package pipe_pkg holds:
  - stage_state_e (EMPTY/ONE/TWO).
  - Per-stage packed payload structs (exe_mem_t, etc.).
  - localparam masks (EXE_MEM_CTRL_MASK covering RegWrite, MemReWr, MemWHB, CSR_sel).
- One sub-module, pipe_stall_ctr: the saturating CNT_W counter with an increment enable.
- The skid entry stays inline.

## Test plan
- Reset release, in_valid=1 with in_data=0x…A5, out_ready=1 → out_valid=1 one cycle later with data A5; stall_cnt=0.
- SKID_EN=1:
  - Stimulus: out_ready=0 for 3 cycles while streaming D0, D1, D2.
  - Required: D0 held in main, D1 in skid; in_ready=0 from the cycle after D1 is accepted; D2 is not accepted; stall_cnt=3.
  - Then out_ready=1: out_data = D0, D1, D2 in consecutive cycles.
- Flush in TWO with in_valid=1 → next cycle out_valid=0, out_data & CTRL_MASK = 0, in_ready=1; the incoming entry is never output.
- Stall counter with CNT_W=4 and 20 stall cycles → stall_cnt=15 and holds; a flush leaves it at 15.
- rst asserted mid-stream in state ONE, between clock edges → out_valid and out_data go to 0 without waiting for clk.
- SKID_EN=0:
  - Full back-pressure: in_ready tracks out_ready in the same cycle.
  - Random valid/ready for 10k cycles: the scoreboard sees every accepted non-flushed payload exactly once, in order.
